// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// Frame layout, receive FSM states and scan-code constants.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int START_IDX  = 0;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  localparam logic [7:0] BREAK  = 8'hF0;
  localparam logic [7:0] EXTEND = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_e;

  // Start low, stop high, odd parity over data+parity.
  function automatic logic frame_ok(
    input logic [FRAME_BITS-1:0] f
  );
    return !f[START_IDX] && f[STOP_IDX] &&
           (^f[PARITY_IDX:1]);
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Generic single-clock byte FIFO.
// Extra pointer MSB separates full from empty.
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int W          = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] MSB_ONLY =
    PW'(1) << DEPTH_LOG2;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = ((wptr_q ^ rptr_q) == MSB_ONLY);
  assign head_o  = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  // Next pointer values; both may advance together.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + PW'(1);
    if (do_rd) rptr_d = rptr_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_wr) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard frame receiver with byte FIFO.
// Synchroniser, receive FSM, timeout and pop edge.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(STOP_IDX);

  logic [SYNC_STAGES-1:0] kclk_q, kdat_q;
  logic                   nd_prev_q;

  rx_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  ovf_q, ovf_d;
  logic                  ferr_q, ferr_d;

  logic       fall, bit_in;
  logic       wr_en, rd_en;
  logic       full, empty;
  logic [7:0] head;

  assign fall   = kclk_q[SYNC_STAGES-1] &&
                  !kclk_q[SYNC_STAGES-2];
  assign bit_in = kdat_q[SYNC_STAGES-2];

  // Pin synchronisers and consumer strobe history.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      kclk_q    <= '1;
      kdat_q    <= '1;
      nd_prev_q <= 1'b1;
    end else begin
      kclk_q    <= {kclk_q[SYNC_STAGES-2:0], ps2_clk};
      kdat_q    <= {kdat_q[SYNC_STAGES-2:0], ps2_data};
      nd_prev_q <= nextdata_n;
    end
  end

  // Receive FSM next state, frame capture, checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    to_d    = to_q;
    ovf_d   = ovf_q;
    ferr_d  = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          frame_d            = '0;
          frame_d[START_IDX] = bit_in;
          cnt_d              = 4'd1;
          to_d               = '0;
          state_d            = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          frame_d[cnt_q] = bit_in;
          to_d           = '0;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = 4'd0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          frame_d = '0;
          to_d    = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok(frame_q)) begin
          if (full) ovf_d = 1'b1;
          else      wr_en = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive FSM and status registers.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      frame_q <= '0;
      to_q    <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rd_en = nd_prev_q && !nextdata_n && !empty;

  ps2_sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .W         (8)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (clrn),
    .wr_en_i  (wr_en),
    .wr_data_i(frame_q[8:1]),
    .rd_en_i  (rd_en),
    .full_o   (full),
    .empty_o  (empty),
    .head_o   (head)
  );

  assign ready     = !empty;
  assign data      = ready ? head : 8'h00;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised scoreboard bench for ps2_rx_fifo.
// Queue model of stored bytes, overflow and errors.
module tb_ps2_rx_fifo;

  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int CAP  = 8;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks   = 0;
  int fails    = 0;
  int err_exp  = 0;
  int err_seen = 0;
  logic       ovf_exp = 1'b0;
  logic [7:0] exp_q[$];

  logic ferr_prev = 1'b0;
  logic nd_prev_m = 1'b1;

  ps2_rx_fifo #(
    .DEPTH_LOG2    (3),
    .SYNC_STAGES   (3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, req);
    end
  endtask

  // Monitor: consumes expected bytes on every pop.
  always @(negedge clk) begin
    if (frame_err) begin
      err_seen++;
      chk("frame_err_one_cycle", {31'd0, ferr_prev}, 0);
    end
    if (nd_prev_m && !nextdata_n && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL pop_data: got %0h, expected no byte",
                 data);
      end else begin
        chk("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
    ferr_prev <= frame_err;
    nd_prev_m <= nextdata_n;
  end

  function automatic logic [10:0] make_frame(
    input logic [7:0] b, input logic bp, input logic bs);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bp;
    f[10]  = ~bs;
    return f;
  endfunction

  // Leaves ps2_clk low after the last falling edge.
  task automatic drive_bits(input logic [10:0] f,
                            input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i != n - 1) begin
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic model_frame(input logic [7:0] b,
                             input logic bp, input logic bs);
    if (bp || bs) err_exp++;
    else if (exp_q.size() < CAP) exp_q.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bp, input logic bs);
    drive_bits(make_frame(b, bp, bs), 11);
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    model_frame(b, bp, bs);
  endtask

  task automatic pop_once(input int low);
    @(posedge clk);
    #2 nextdata_n = 1'b0;
    repeat (low) @(posedge clk);
    #2 nextdata_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, ready},
        {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk({tag, ".head"}, {24'd0, data}, {24'd0, exp_q[0]});
    else
      chk({tag, ".data"}, {24'd0, data}, 0);
    chk({tag, ".overflow"}, {31'd0, overflow},
        {31'd0, ovf_exp});
    chk({tag, ".errors"}, err_seen, err_exp);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    logic        bp, bs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'd0, ready}, 0);
    chk("rst.data", {24'd0, data}, 0);
    chk("rst.overflow", {31'd0, overflow}, 0);
    chk("rst.frame_err", {31'd0, frame_err}, 0);
    @(posedge clk);
    #2 clrn = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame with exact write latency.
    f = make_frame(8'h1C, 1'b0, 1'b0);
    drive_bits(f, 11);
    repeat (3) @(negedge clk);
    chk("lat.early", {31'd0, ready}, 0);
    @(negedge clk);
    chk("lat.ready", {31'd0, ready}, 1);
    chk("lat.data", {24'd0, data}, 8'h1C);
    repeat (HALF - 4) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    model_frame(8'h1C, 1'b0, 1'b0);
    check_state("t1");
    pop_once(5);
    check_state("t1pop");

    // Long-low pops pop once each.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_state("t2");
    pop_once(200);
    check_state("t2pop1");
    pop_once(200);
    check_state("t2pop2");

    // Parity and stop errors.
    send_frame(8'h23, 1'b1, 1'b0);
    check_state("t3par");
    send_frame(8'h23, 1'b0, 1'b1);
    check_state("t3stop");

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      check_state("t4fill");
    end
    for (int i = 0; i < 9; i++) begin
      pop_once($urandom_range(1, 30));
      check_state("t4drain");
    end

    // Abandoned partial frame.
    drive_bits(make_frame(8'hAA, 1'b0, 1'b0), 5);
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h42, 1'b0, 1'b0);
    check_state("t5");
    pop_once(3);
    check_state("t5pop");

    // Reset mid-frame with bytes queued.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    drive_bits(make_frame(8'h55, 1'b0, 1'b0), 7);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    @(posedge clk);
    #2 clrn = 1'b0;
    @(posedge clk);
    #2 clrn = 1'b1;
    @(negedge clk);
    chk("t6.ready", {31'd0, ready}, 0);
    chk("t6.overflow", {31'd0, overflow}, 0);
    exp_q.delete();
    ovf_exp  = 1'b0;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(8'h33, 1'b0, 1'b0);
    check_state("t6");

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 9) == 0);
      send_frame(b, bp, bs);
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) begin
        pop_once($urandom_range(1, 50));
        check_state("rndpop");
      end
    end

    check_state("final");
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 keyboard receiver and byte buffer; sits directly upstream of the note/chord decoder.
- Deserialises 11-bit PS/2 frames from the keyboard pins and stores validated scan-code bytes in a small FIFO.
- The decoder reads bytes through a ready/nextdata_n handshake.
- Designed so a consumer running on a slow divided clock can drain the FIFO safely.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8).
- SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data (minimum 2).
- TIMEOUT_CYCLES, 10000, clk cycles without a PS/2 falling edge before a partial frame is abandoned (200 us at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- clrn  in  1  reset, synchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- nextdata_n  in  1  consumer pop request, active-low; a pop is taken on its high-to-low transition.
- data  out  8  FIFO head byte; valid while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky flag: a valid frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse when a frame fails its start, stop or parity check.

Behaviour:
- Reset (clrn=0 at posedge clk) forces:
  - outputs: ready=0, data=8'h00, overflow=0, frame_err=0.
  - internal: bit counter=0, shift register=0, FIFO pointers=0, timeout counter=0.
  - synchroniser chains and the nextdata_n history flop preset to 1.
  - Reset takes priority over every other event; a partial frame is discarded.
- Synchronisation: ps2_clk and ps2_data pass through SYNC_STAGES flops. A falling edge is detected when the last two ps2_clk stages read 1 then 0. Data is sampled from the synchronised ps2_data on that same cycle.
- Receive FSM (states IDLE, SHIFT, CHECK):
  - IDLE: on a falling edge, capture bit0 (start bit) and move to SHIFT with count=1.
  - SHIFT: each falling edge captures one bit. Data bits arrive LSB first at count 1..8, parity at 9, stop at 10. After the stop bit, go to CHECK.
  - CHECK: lasts one cycle. The frame is valid when start=0, stop=1, and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Valid and FIFO not full: write the byte.
    - Valid and FIFO full: drop the byte and set overflow=1.
    - Invalid: drop the byte and pulse frame_err=1 for one cycle.
    - Always return to IDLE.
- Timeout: in SHIFT, a counter increments every cycle and clears on each falling edge. When it reaches TIMEOUT_CYCLES-1, return to IDLE, discard the partial frame, and raise no error.
- FIFO:
  - Pointers are DEPTH_LOG2+1 bits wide. Empty when the pointers are equal; full when they differ only in the MSB.
  - data is combinationally mem[rptr]; ready = !empty.
  - Latency: ready rises on the cycle after CHECK, i.e. 2 clk cycles after the cycle the 11th falling edge is detected.
- Pop: occurs when nextdata_n_prev=1, nextdata_n=0 and ready=1.
  - nextdata_n held low for many cycles pops exactly once.
  - A pop while empty is ignored.
- Simultaneous write and pop: both take effect. Full/empty are evaluated on the pre-edge pointers, so a write arriving while full is still dropped (overflow=1) even if a pop occurs in the same cycle.
- overflow clears only on reset.
- Pointers wrap modulo 2**(DEPTH_LOG2+1).

Decomposition:
- Package ps2_pkg:
  - frame constants: FRAME_BITS=11, START_IDX=0, PARITY_IDX=9, STOP_IDX=10.
  - receive FSM state encoding.
  - scan-code constants: BREAK=8'hF0, EXTEND=8'hE0.
- Sub-module ps2_sync_fifo: generic DEPTH_LOG2 x 8 FIFO with wr_en, rd_en, full, empty, head. The top block holds the synchroniser, FSM, timeout and pop-edge logic.

Test Plan:
- Single frame 0x1C (bits 0, 0011_1000 LSB-first, parity 0, stop 1) at 12.5 kHz PS/2 clock -> ready=1 two cycles after the 11th edge, data=8'h1C, frame_err stays 0.
- Frames 0xF0 then 0x1C, then nextdata_n pulsed low for 200 cycles twice -> first data=F0; after the first pop data=1C; after the second pop ready=0; each long-low pulse pops exactly once.
- Frame 0x23 with parity flipped -> frame_err pulses for 1 cycle, ready stays 0; stop bit=0 gives the same result.
- Nine valid frames 0x01..0x09 with no pops -> after the 8th, full; the 9th sets overflow=1; pops then return 0x01..0x08 in order, then ready=0, overflow remains 1.
- Five bits of a frame, then idle for TIMEOUT_CYCLES+10, then a full frame 0x42 -> only 0x42 is stored, no frame_err.
- clrn low for 1 cycle mid-frame (after bit 6) with 2 bytes queued -> ready=0 and overflow=0 the next cycle; a following frame 0x33 is received correctly.
